// File: rtl/execute_mul_result_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module   : execute_mul_result_buffer_pkg
// Purpose  : Shared flag indices and buffer entry layout for the MUL result stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package execute_mul_result_buffer_pkg;

  localparam int FLAG_SF = 4;
  localparam int FLAG_OF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_PF = 1;
  localparam int FLAG_ZF = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
    logic        flags_write;
    logic        writeback;
    logic [4:0]  dest;
  } mul_entry_t;

endpackage

`default_nettype wire

// File: rtl/execute_mul_result_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : execute_mul_result_buffer_if
// Purpose  : Upstream (multiplier) and downstream (writeback) handshake bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface execute_mul_result_buffer_if;

  logic        iPREV_VALID;
  logic        oPREV_BUSY;
  logic [31:0] iPREV_DATA;
  logic [4:0]  iPREV_FLAGS;
  logic        iPREV_FLAGS_WRITE;
  logic        iPREV_WRITEBACK;
  logic [4:0]  iPREV_DESTINATION;

  logic        oNEXT_VALID;
  logic        iNEXT_BUSY;
  logic [31:0] oNEXT_DATA;
  logic        oNEXT_WRITEBACK;
  logic [4:0]  oNEXT_DESTINATION;

  modport master (
    output iPREV_VALID, iPREV_DATA, iPREV_FLAGS, iPREV_FLAGS_WRITE,
           iPREV_WRITEBACK, iPREV_DESTINATION, iNEXT_BUSY,
    input  oPREV_BUSY, oNEXT_VALID, oNEXT_DATA, oNEXT_WRITEBACK, oNEXT_DESTINATION
  );

  modport slave (
    input  iPREV_VALID, iPREV_DATA, iPREV_FLAGS, iPREV_FLAGS_WRITE,
           iPREV_WRITEBACK, iPREV_DESTINATION, iNEXT_BUSY,
    output oPREV_BUSY, oNEXT_VALID, oNEXT_DATA, oNEXT_WRITEBACK, oNEXT_DESTINATION
  );

endinterface

`default_nettype wire

// File: rtl/execute_mul_result_fifo.sv
//------------------------------------------------------------------------------
// Module   : execute_mul_result_fifo
// Purpose  : In-order entry FIFO with occupancy count and pending flag-write OR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_mul_result_fifo
  import execute_mul_result_buffer_pkg::*;
#(
  parameter int P_DEPTH   = 2,
  parameter int P_DEPTH_N = 1
) (
  input  wire             clk,
  input  wire             rst_n,
  input  wire             i_clear,
  input  wire             i_push,
  input  wire             i_pop,
  input  wire mul_entry_t i_wr_entry,
  output mul_entry_t      o_head,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_flags_write_any
);

  localparam int PTR_W = P_DEPTH_N;
  localparam int CNT_W = P_DEPTH_N + 1;

  mul_entry_t [P_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [P_DEPTH-1:0]       slot_fw;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_push) begin
        mem_d[wr_ptr_q] = i_wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (i_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_occupancy
    logic [PTR_W-1:0] offset;
    assign offset      = PTR_W'(gi) - rd_ptr_q;
    assign slot_fw[gi] = mem_q[gi].flags_write && ({1'b0, offset} < count_q);
  end

  assign o_head            = mem_q[rd_ptr_q];
  assign o_full            = (count_q == CNT_W'(P_DEPTH));
  assign o_empty           = (count_q == '0);
  assign o_flags_write_any = |slot_fw;

endmodule

`default_nettype wire

// File: rtl/execute_mul_result_buffer.sv
//------------------------------------------------------------------------------
// Module   : execute_mul_result_buffer
// Purpose  : Buffers multiplier results for writeback and owns the flag register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_mul_result_buffer
  import execute_mul_result_buffer_pkg::*;
#(
  parameter int P_DEPTH   = 2,
  parameter int P_DEPTH_N = 1
) (
  input  wire                          iCLOCK,
  input  wire                          inRESET,
  input  wire                          iRESET_SYNC,
  input  wire                          iFLUSH,
  execute_mul_result_buffer_if.slave   bus,
  output logic [4:0]                   oFLAGS_REG,
  output logic                         oFLAGS_PENDING
);

  mul_entry_t wr_entry;
  mul_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fw_any;
  logic       clear;
  logic       push;
  logic       pop;
  logic [4:0] flags_q, flags_d;

  assign wr_entry.data        = bus.iPREV_DATA;
  assign wr_entry.flags       = bus.iPREV_FLAGS;
  assign wr_entry.flags_write = bus.iPREV_FLAGS_WRITE;
  assign wr_entry.writeback   = bus.iPREV_WRITEBACK;
  assign wr_entry.dest        = bus.iPREV_DESTINATION;

  // Flush/sync-clear win over any concurrent push or commit.
  assign clear = iRESET_SYNC | iFLUSH;
  assign push  = bus.iPREV_VALID & ~fifo_full & ~clear;
  assign pop   = ~fifo_empty & ~bus.iNEXT_BUSY & ~clear;

  execute_mul_result_fifo #(
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_fifo (
    .clk               (iCLOCK),
    .rst_n             (inRESET),
    .i_clear           (clear),
    .i_push            (push),
    .i_pop             (pop),
    .i_wr_entry        (wr_entry),
    .o_head            (head),
    .o_full            (fifo_full),
    .o_empty           (fifo_empty),
    .o_flags_write_any (fw_any)
  );

  always_comb begin
    flags_d = flags_q;
    if (iRESET_SYNC) begin
      flags_d = '0;
    end else if (pop && head.flags_write) begin
      flags_d = head.flags;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.oPREV_BUSY        = fifo_full;
  assign bus.oNEXT_VALID       = ~fifo_empty;
  assign bus.oNEXT_DATA        = head.data;
  assign bus.oNEXT_WRITEBACK   = head.writeback;
  assign bus.oNEXT_DESTINATION = head.dest;
  assign oFLAGS_REG            = flags_q;
  assign oFLAGS_PENDING        = fw_any;

endmodule

`default_nettype wire
